// File: rtl/icb_arb_pkg.sv
// Shared types and constants for the flat ICB two-master arbiter.
package icb_arb_pkg;

  // Transaction phases of the arbiter.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RSP   = 2'd3
  } arb_state_e;

  // Number of masters sharing the slave port.
  localparam int NUM_M = 2;

endpackage

// File: rtl/icb_rr_pick2.sv
// Combinational two-way round-robin pick: the requester other than the
// last winner has priority, otherwise the sole requester wins.
module icb_rr_pick2
  import icb_arb_pkg::*;
(
  input  logic [NUM_M-1:0] req_i,
  input  logic             last_gnt_i,
  output logic             gnt_id_o,
  output logic             any_req_o
);

  // Priority rotates away from the previous winner.
  always_comb begin
    any_req_o = |req_i;
    if (last_gnt_i) begin
      gnt_id_o = req_i[0] ? 1'b0 : 1'b1;
    end else begin
      gnt_id_o = req_i[1] ? 1'b1 : 1'b0;
    end
  end

endmodule

// File: rtl/icb_flat_arbiter2.sv
// Shares one flat ICB slave port between two flat ICB masters.
// Round-robin at transaction granularity; the grant is held from command
// acceptance until the final response beat, one transaction in flight.
module icb_flat_arbiter2
  import icb_arb_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 19,
  parameter int LEN_W  = 3,
  parameter int MW     = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  // master 0
  input  logic              m0_icb_cmd_valid,
  output logic              m0_icb_cmd_ready,
  input  logic [ADDR_W-1:0] m0_icb_cmd_addr,
  input  logic              m0_icb_cmd_read,
  input  logic [LEN_W-1:0]  m0_icb_cmd_len,
  input  logic [WIDTH-1:0]  m0_icb_cmd_wdata,
  input  logic [MW-1:0]     m0_icb_cmd_wmask,
  input  logic              m0_icb_w_valid,
  output logic              m0_icb_w_ready,
  output logic              m0_icb_rsp_valid,
  input  logic              m0_icb_rsp_ready,
  output logic [WIDTH-1:0]  m0_icb_rsp_rdata,
  output logic              m0_icb_rsp_err,
  // master 1
  input  logic              m1_icb_cmd_valid,
  output logic              m1_icb_cmd_ready,
  input  logic [ADDR_W-1:0] m1_icb_cmd_addr,
  input  logic              m1_icb_cmd_read,
  input  logic [LEN_W-1:0]  m1_icb_cmd_len,
  input  logic [WIDTH-1:0]  m1_icb_cmd_wdata,
  input  logic [MW-1:0]     m1_icb_cmd_wmask,
  input  logic              m1_icb_w_valid,
  output logic              m1_icb_w_ready,
  output logic              m1_icb_rsp_valid,
  input  logic              m1_icb_rsp_ready,
  output logic [WIDTH-1:0]  m1_icb_rsp_rdata,
  output logic              m1_icb_rsp_err,
  // slave (bridge side)
  output logic              s_icb_cmd_valid,
  input  logic              s_icb_cmd_ready,
  output logic [ADDR_W-1:0] s_icb_cmd_addr,
  output logic              s_icb_cmd_read,
  output logic [LEN_W-1:0]  s_icb_cmd_len,
  output logic [WIDTH-1:0]  s_icb_cmd_wdata,
  output logic [MW-1:0]     s_icb_cmd_wmask,
  output logic              s_icb_w_valid,
  input  logic              s_icb_w_ready,
  input  logic              s_icb_rsp_valid,
  output logic              s_icb_rsp_ready,
  input  logic [WIDTH-1:0]  s_icb_rsp_rdata,
  input  logic              s_icb_rsp_err,
  // status
  output logic              arb_busy,
  output logic              arb_gnt
);

  localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

  arb_state_e       state_q;
  logic             gnt_q;
  logic             last_gnt_q;
  logic [LEN_W:0]   beats_q;
  logic [LEN_W:0]   w_cnt_q;
  logic [LEN_W:0]   w_cnt_d;
  logic             is_rd_q;

  logic             pick_id;
  logic             any_req;

  logic             sel_cmd_valid;
  logic             sel_read;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0] sel_len;
  logic [WIDTH-1:0] sel_wdata;
  logic [MW-1:0]    sel_wmask;
  logic             sel_w_valid;
  logic             sel_rsp_ready;
  logic [LEN_W:0]   sel_beats;

  logic             in_cmd;
  logic             w_open;
  logic             in_rsp;
  logic             cmd_hs;
  logic             w_hs;
  logic             rsp_hs;
  logic             rsp_last;

  icb_rr_pick2 u_pick (
    .req_i      ({m1_icb_cmd_valid, m0_icb_cmd_valid}),
    .last_gnt_i (last_gnt_q),
    .gnt_id_o   (pick_id),
    .any_req_o  (any_req)
  );

  // Granted master's request-side signals.
  always_comb begin
    if (gnt_q) begin
      sel_cmd_valid = m1_icb_cmd_valid;
      sel_read      = m1_icb_cmd_read;
      sel_addr      = m1_icb_cmd_addr;
      sel_len       = m1_icb_cmd_len;
      sel_wdata     = m1_icb_cmd_wdata;
      sel_wmask     = m1_icb_cmd_wmask;
      sel_w_valid   = m1_icb_w_valid;
      sel_rsp_ready = m1_icb_rsp_ready;
    end else begin
      sel_cmd_valid = m0_icb_cmd_valid;
      sel_read      = m0_icb_cmd_read;
      sel_addr      = m0_icb_cmd_addr;
      sel_len       = m0_icb_cmd_len;
      sel_wdata     = m0_icb_cmd_wdata;
      sel_wmask     = m0_icb_cmd_wmask;
      sel_w_valid   = m0_icb_w_valid;
      sel_rsp_ready = m0_icb_rsp_ready;
    end
  end

  assign sel_beats = {1'b0, sel_len} + CNT_ONE;

  // Channel windows; reset closes every handshake immediately. The W
  // channel opens in CMD so a master may present write data early, and
  // closes as soon as the beat count is complete.
  assign in_cmd = !rst && (state_q == CMD);
  assign in_rsp = !rst && (state_q == RSP);
  assign w_open = !rst && (((state_q == CMD) && !sel_read && (w_cnt_q < sel_beats)) ||
                           ((state_q == WDATA) && (w_cnt_q < beats_q)));

  assign s_icb_cmd_valid = in_cmd && sel_cmd_valid;
  assign s_icb_cmd_addr  = sel_addr;
  assign s_icb_cmd_read  = sel_read;
  assign s_icb_cmd_len   = sel_len;
  assign s_icb_cmd_wdata = sel_wdata;
  assign s_icb_cmd_wmask = sel_wmask;
  assign s_icb_w_valid   = w_open && sel_w_valid;
  assign s_icb_rsp_ready = in_rsp && sel_rsp_ready;

  assign cmd_hs   = s_icb_cmd_valid && s_icb_cmd_ready;
  assign w_hs     = s_icb_w_valid && s_icb_w_ready;
  assign rsp_hs   = s_icb_rsp_valid && s_icb_rsp_ready;
  assign rsp_last = !is_rd_q || (beats_q == CNT_ONE);
  assign w_cnt_d  = w_hs ? (w_cnt_q + CNT_ONE) : w_cnt_q;

  // Return-path routing: only the granted master sees slave handshakes.
  always_comb begin
    m0_icb_cmd_ready = in_cmd && !gnt_q && s_icb_cmd_ready;
    m1_icb_cmd_ready = in_cmd &&  gnt_q && s_icb_cmd_ready;
    m0_icb_w_ready   = w_open && !gnt_q && s_icb_w_ready;
    m1_icb_w_ready   = w_open &&  gnt_q && s_icb_w_ready;
    m0_icb_rsp_valid = in_rsp && !gnt_q && s_icb_rsp_valid;
    m1_icb_rsp_valid = in_rsp &&  gnt_q && s_icb_rsp_valid;
    m0_icb_rsp_rdata = (in_rsp && !gnt_q) ? s_icb_rsp_rdata : '0;
    m1_icb_rsp_rdata = (in_rsp &&  gnt_q) ? s_icb_rsp_rdata : '0;
    m0_icb_rsp_err   = in_rsp && !gnt_q && s_icb_rsp_err;
    m1_icb_rsp_err   = in_rsp &&  gnt_q && s_icb_rsp_err;
  end

  assign arb_busy = (state_q != IDLE);
  assign arb_gnt  = gnt_q;

  // Transaction FSM: grant, command, write beats, response beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      beats_q    <= '0;
      w_cnt_q    <= '0;
      is_rd_q    <= 1'b0;
    end else begin
      w_cnt_q <= w_cnt_d;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q   <= pick_id;
            state_q <= CMD;
          end
        end
        CMD: begin
          if (cmd_hs) begin
            beats_q <= sel_beats;
            is_rd_q <= sel_read;
            if (sel_read || (w_cnt_d == sel_beats)) begin
              state_q <= RSP;
            end else begin
              state_q <= WDATA;
            end
          end
        end
        WDATA: begin
          if (w_hs && (w_cnt_d == beats_q)) begin
            state_q <= RSP;
          end
        end
        RSP: begin
          if (rsp_hs) begin
            beats_q <= beats_q - CNT_ONE;
            if (rsp_last) begin
              last_gnt_q <= gnt_q;
              w_cnt_q    <= '0;
              state_q    <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icb_flat_arbiter2.sv
// Scoreboard bench for icb_flat_arbiter2 with a behavioural bridge model.
module tb_icb_flat_arbiter2;
  import icb_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        mc_valid [2];
  logic        mc_read  [2];
  logic [18:0] mc_addr  [2];
  logic [2:0]  mc_len   [2];
  logic [31:0] mc_wdata [2];
  logic [3:0]  mc_wmask [2];
  logic        mw_valid [2];
  logic        mr_ready [2];
  logic        mc_ready [2];
  logic        mw_ready [2];
  logic        mr_valid [2];
  logic [31:0] mr_rdata [2];
  logic        mr_err   [2];

  logic        s_cmd_valid, s_cmd_ready, s_cmd_read, s_w_valid, s_w_ready;
  logic        s_rsp_valid, s_rsp_ready, s_rsp_err;
  logic [18:0] s_cmd_addr;
  logic [2:0]  s_cmd_len;
  logic [31:0] s_cmd_wdata, s_rsp_rdata;
  logic [3:0]  s_cmd_wmask;
  logic        arb_busy, arb_gnt;

  icb_flat_arbiter2 dut (
    .clk(clk), .rst(rst),
    .m0_icb_cmd_valid(mc_valid[0]), .m0_icb_cmd_ready(mc_ready[0]),
    .m0_icb_cmd_addr(mc_addr[0]), .m0_icb_cmd_read(mc_read[0]),
    .m0_icb_cmd_len(mc_len[0]), .m0_icb_cmd_wdata(mc_wdata[0]),
    .m0_icb_cmd_wmask(mc_wmask[0]), .m0_icb_w_valid(mw_valid[0]),
    .m0_icb_w_ready(mw_ready[0]), .m0_icb_rsp_valid(mr_valid[0]),
    .m0_icb_rsp_ready(mr_ready[0]), .m0_icb_rsp_rdata(mr_rdata[0]),
    .m0_icb_rsp_err(mr_err[0]),
    .m1_icb_cmd_valid(mc_valid[1]), .m1_icb_cmd_ready(mc_ready[1]),
    .m1_icb_cmd_addr(mc_addr[1]), .m1_icb_cmd_read(mc_read[1]),
    .m1_icb_cmd_len(mc_len[1]), .m1_icb_cmd_wdata(mc_wdata[1]),
    .m1_icb_cmd_wmask(mc_wmask[1]), .m1_icb_w_valid(mw_valid[1]),
    .m1_icb_w_ready(mw_ready[1]), .m1_icb_rsp_valid(mr_valid[1]),
    .m1_icb_rsp_ready(mr_ready[1]), .m1_icb_rsp_rdata(mr_rdata[1]),
    .m1_icb_rsp_err(mr_err[1]),
    .s_icb_cmd_valid(s_cmd_valid), .s_icb_cmd_ready(s_cmd_ready),
    .s_icb_cmd_addr(s_cmd_addr), .s_icb_cmd_read(s_cmd_read),
    .s_icb_cmd_len(s_cmd_len), .s_icb_cmd_wdata(s_cmd_wdata),
    .s_icb_cmd_wmask(s_cmd_wmask), .s_icb_w_valid(s_w_valid),
    .s_icb_w_ready(s_w_ready), .s_icb_rsp_valid(s_rsp_valid),
    .s_icb_rsp_ready(s_rsp_ready), .s_icb_rsp_rdata(s_rsp_rdata),
    .s_icb_rsp_err(s_rsp_err),
    .arb_busy(arb_busy), .arb_gnt(arb_gnt)
  );

  int compared = 0;
  int mism = 0;

  // Expected traffic: {addr,read,len}, {wdata,wmask}, {err,rdata}.
  logic [22:0] exp_cmd [$];
  logic [35:0] exp_w   [$];
  logic [32:0] exp_r0  [$];
  logic [32:0] exp_r1  [$];

  // Bridge model knobs, written only by the stimulus process.
  logic [31:0] rd_base = 32'h0;
  int          err_beat = -1;
  int          stall_req = 0;
  bit          tog [2];
  logic [31:0] wtab [2][8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mism++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_rd(input int m, input logic [31:0] base, input int len, input int eb);
    for (int i = 0; i <= len; i++) begin
      logic [32:0] e;
      e = {(i == eb) ? 1'b1 : 1'b0, base + 32'(i)};
      if (m == 0) exp_r0.push_back(e); else exp_r1.push_back(e);
    end
  endtask

  // Master transaction: command, then (for writes) nw W beats.
  task automatic txn(input int m, input logic [18:0] addr, input logic rd,
                     input logic [2:0] len, input bit early_w, input int nw);
    bit cmd_done;
    cmd_done = 0;
    fork
      begin
        int t; bit hs;
        @(posedge clk); #1;
        mc_valid[m] = 1'b1; mc_addr[m] = addr; mc_read[m] = rd; mc_len[m] = len;
        t = 0; hs = 0;
        while (!hs && t < 300) begin
          @(negedge clk); hs = mc_valid[m] && mc_ready[m];
          @(posedge clk); #1; t++;
        end
        mc_valid[m] = 1'b0;
        if (!hs) chk($sformatf("m%0d_cmd_timeout", m), 64'(0), 64'(1));
        cmd_done = 1;
      end
      begin
        if (!rd) begin
          if (early_w) begin @(posedge clk); #1; end
          else wait (cmd_done);
          for (int i = 0; i < nw; i++) begin
            int t; bit hs;
            mw_valid[m] = 1'b1; mc_wdata[m] = wtab[m][i]; mc_wmask[m] = 4'hF;
            t = 0; hs = 0;
            while (!hs && t < 300) begin
              @(negedge clk); hs = mw_valid[m] && mw_ready[m];
              @(posedge clk); #1; t++;
            end
            if (!hs) chk($sformatf("m%0d_w_timeout", m), 64'(0), 64'(1));
          end
          mw_valid[m] = 1'b0;
        end
      end
    join
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    do begin @(negedge clk); t++; end
    while ((arb_busy || s_rsp_valid || exp_cmd.size() != 0 || exp_w.size() != 0 ||
            exp_r0.size() != 0 || exp_r1.size() != 0) && t < 500);
    chk({nm, "_drain"}, 64'(exp_cmd.size() + exp_w.size() + exp_r0.size() + exp_r1.size()), 64'(0));
    chk({nm, "_idle"}, 64'(arb_busy), 64'(0));
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1; rst = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  // Response-ready drivers: steady 1 or toggling per master.
  initial begin
    mr_ready[0] = 1'b1; mr_ready[1] = 1'b1;
    forever begin
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) mr_ready[m] = tog[m] ? !mr_ready[m] : 1'b1;
    end
  end

  // Bridge model: accepts one command, absorbs W beats, returns response beats.
  initial begin
    bit c_hs, w_hs, r_hs, rst_s;
    bit got, in_rsp, srd, cv;
    logic cr; int cl, slen, wc, bc, stall;
    s_cmd_ready = 0; s_w_ready = 0; s_rsp_valid = 0; s_rsp_rdata = 0; s_rsp_err = 0;
    got = 0; in_rsp = 0; srd = 0; slen = 0; wc = 0; bc = 0; stall = 0;
    forever begin
      @(negedge clk);
      rst_s = rst; cv = s_cmd_valid; cr = s_cmd_read; cl = int'(s_cmd_len);
      c_hs = s_cmd_valid && s_cmd_ready;
      w_hs = s_w_valid && s_w_ready;
      r_hs = s_rsp_valid && s_rsp_ready;
      @(posedge clk); #1;
      if (rst_s) begin
        got = 0; in_rsp = 0; wc = 0; bc = 0; stall = 0;
        s_cmd_ready = 0; s_w_ready = 0; s_rsp_valid = 0; s_rsp_rdata = 0; s_rsp_err = 0;
      end else begin
        if (c_hs) begin got = 1; srd = cr; slen = cl; stall = 0; end
        else if (cv && !got) stall++;
        if (w_hs) wc++;
        if (r_hs) begin
          bc++;
          if (!srd || bc == slen + 1) begin in_rsp = 0; got = 0; wc = 0; bc = 0; end
        end
        if (got && !in_rsp && (srd || wc == slen + 1)) begin in_rsp = 1; bc = 0; end
        s_cmd_ready = !got && (stall >= stall_req);
        s_w_ready   = 1'b1;
        s_rsp_valid = in_rsp;
        s_rsp_rdata = (in_rsp && srd) ? rd_base + 32'(bc) : 32'h0;
        s_rsp_err   = in_rsp && srd && (bc == err_beat);
      end
    end
  end

  // Monitor: pops the scoreboard on every DUT-presented handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (s_cmd_valid && s_cmd_ready) begin
        if (exp_cmd.size() == 0) chk("s_cmd_unexpected", 64'(s_cmd_addr), 64'h7FFFF_0000);
        else chk("s_cmd", 64'({s_cmd_addr, s_cmd_read, s_cmd_len}), 64'(exp_cmd.pop_front()));
      end
      if (s_w_valid && s_w_ready) begin
        if (exp_w.size() == 0) chk("s_w_unexpected", 64'(s_cmd_wdata), 64'hFFFF_0000_0000);
        else chk("s_w", 64'({s_cmd_wdata, s_cmd_wmask}), 64'(exp_w.pop_front()));
      end
      if (mr_valid[0] && mr_ready[0]) begin
        if (exp_r0.size() == 0) chk("m0_rsp_unexpected", 64'(mr_rdata[0]), 64'hFFFF_0000_0000);
        else chk("m0_rsp", 64'({mr_err[0], mr_rdata[0]}), 64'(exp_r0.pop_front()));
      end
      if (mr_valid[1] && mr_ready[1]) begin
        if (exp_r1.size() == 0) chk("m1_rsp_unexpected", 64'(mr_rdata[1]), 64'hFFFF_0000_0000);
        else chk("m1_rsp", 64'({mr_err[1], mr_rdata[1]}), 64'(exp_r1.pop_front()));
      end
      for (int m = 0; m < 2; m++)
        if (int'(arb_gnt) != m)
          chk($sformatf("m%0d_nongrant_quiet", m),
              64'({mc_ready[m], mw_ready[m], mr_valid[m], mr_err[m], mr_rdata[m]}), 64'(0));
      if (s_rsp_valid) chk("s_rsp_only_in_rsp", 64'(dut.state_q == RSP), 64'(1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    int n, t;
    for (int m = 0; m < 2; m++) begin
      mc_valid[m] = 0; mc_read[m] = 0; mc_addr[m] = 0; mc_len[m] = 0;
      mc_wdata[m] = 0; mc_wmask[m] = 0; mw_valid[m] = 0; tog[m] = 0;
      for (int i = 0; i < 8; i++) wtab[m][i] = 32'h0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 64'({s_cmd_valid, s_w_valid, s_rsp_ready, mc_ready[0], mc_ready[1],
                             mw_ready[0], mw_ready[1], mr_valid[0], mr_valid[1]}), 64'(0));
    chk("rst_busy", 64'(arb_busy), 64'(0));
    chk("rst_gnt", 64'(arb_gnt), 64'(0));
    chk("rst_last_gnt", 64'(dut.last_gnt_q), 64'(1));
    @(posedge clk); #1; rst = 1'b0;

    // Single read, m0, 4 beats.
    rd_base = 32'hA0; err_beat = -1;
    exp_cmd.push_back({19'h100, 1'b1, 3'd3});
    push_rd(0, 32'hA0, 3, -1);
    txn(0, 19'h100, 1'b1, 3'd3, 1'b0, 0);
    n = 0; t = 0;
    while (n < 4 && t < 200) begin
      @(negedge clk);
      if (mr_valid[0] && mr_ready[0]) n++;
      t++;
    end
    chk("t1_beats", 64'(n), 64'(4));
    chk("t1_busy_last_beat", 64'(arb_busy), 64'(1));
    @(negedge clk);
    chk("t1_busy_dropped", 64'(arb_busy), 64'(0));
    wait_idle("t1");

    // Write with early W, m1, 2 beats.
    wtab[1][0] = 32'hDEAD; wtab[1][1] = 32'hBEEF;
    exp_cmd.push_back({19'h200, 1'b0, 3'd1});
    exp_w.push_back({32'hDEAD, 4'hF});
    exp_w.push_back({32'hBEEF, 4'hF});
    exp_r1.push_back({1'b0, 32'h0});
    txn(1, 19'h200, 1'b0, 3'd1, 1'b1, 2);
    wait_idle("t2");

    // Simultaneous requests from reset: strict alternation m0,m1,...
    do_reset(2);
    rd_base = 32'h50;
    for (int k = 0; k < 3; k++) begin
      exp_cmd.push_back({19'h10 + 19'(k * 16), 1'b1, 3'd0});
      exp_cmd.push_back({19'h11 + 19'(k * 16), 1'b1, 3'd0});
    end
    push_rd(0, 32'h50, 0, -1); push_rd(0, 32'h50, 0, -1); push_rd(0, 32'h50, 0, -1);
    push_rd(1, 32'h50, 0, -1); push_rd(1, 32'h50, 0, -1); push_rd(1, 32'h50, 0, -1);
    fork
      begin
        txn(0, 19'h10, 1'b1, 3'd0, 1'b0, 0);
        txn(0, 19'h20, 1'b1, 3'd0, 1'b0, 0);
        txn(0, 19'h30, 1'b1, 3'd0, 1'b0, 0);
      end
      begin
        txn(1, 19'h11, 1'b1, 3'd0, 1'b0, 0);
        txn(1, 19'h21, 1'b1, 3'd0, 1'b0, 0);
        txn(1, 19'h31, 1'b1, 3'd0, 1'b0, 0);
      end
    join
    wait_idle("t3");

    // Backpressure: command stall plus toggling rsp_ready on an 8-beat read.
    stall_req = 5; tog[0] = 1'b1; rd_base = 32'hC0;
    exp_cmd.push_back({19'h300, 1'b1, 3'd7});
    push_rd(0, 32'hC0, 7, -1);
    txn(0, 19'h300, 1'b1, 3'd7, 1'b0, 0);
    stall_req = 0;
    wait_idle("t4");
    tog[0] = 1'b0;

    // Error on the second beat (index 1) of a 4-beat read.
    rd_base = 32'hE0; err_beat = 1;
    exp_cmd.push_back({19'h340, 1'b1, 3'd3});
    push_rd(0, 32'hE0, 3, 1);
    txn(0, 19'h340, 1'b1, 3'd3, 1'b0, 0);
    wait_idle("t5");
    err_beat = -1;

    // Reset in WDATA after 1 of 4 beats, then an m1-only request.
    for (int i = 0; i < 4; i++) wtab[0][i] = 32'h1111_0000 + 32'(i);
    exp_cmd.push_back({19'h400, 1'b0, 3'd3});
    exp_w.push_back({32'h1111_0000, 4'hF});
    txn(0, 19'h400, 1'b0, 3'd3, 1'b0, 1);
    @(negedge clk);
    chk("t6_in_wdata", 64'(dut.state_q == WDATA), 64'(1));
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_gated", 64'({s_cmd_valid, s_w_valid, s_rsp_ready, mw_ready[0], mr_valid[0]}), 64'(0));
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("t6_idle", 64'(arb_busy), 64'(0));
    chk("t6_last_gnt", 64'(dut.last_gnt_q), 64'(1));
    chk("t6_w_cnt", 64'(dut.w_cnt_q), 64'(0));
    chk("t6_valids", 64'({s_cmd_valid, s_w_valid, mr_valid[0], mr_valid[1]}), 64'(0));
    rd_base = 32'h60;
    exp_cmd.push_back({19'h500, 1'b1, 3'd0});
    push_rd(1, 32'h60, 0, -1);
    txn(1, 19'h500, 1'b1, 3'd0, 1'b0, 0);
    chk("t6_gnt_m1", 64'(arb_gnt), 64'(1));
    wait_idle("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule

// File: doc/icb_flat_arbiter2.md
Name: icb_flat_arbiter2

Overview:
- Shares one flat ICB slave port (top_sram_icb_bridge side) between two flat ICB masters (m0, m1), e.g. the MMA load engine and the host/DMA path.
- Arbitration is round-robin at transaction granularity.
- The grant is held from command acceptance until the final response beat.
- At most one transaction is outstanding on the slave port.

Parameters:
- WIDTH, 32, data width
- ADDR_W, 19, address width
- LEN_W, 3, burst length field width; beats = len+1
- MW, WIDTH/8, write mask width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mN_icb_cmd_valid / mN_icb_cmd_ready, N=0,1  in/out  1  master N command handshake
- mN_icb_cmd_addr  in  ADDR_W  master N address
- mN_icb_cmd_read  in  1  1 = read
- mN_icb_cmd_len  in  LEN_W  beats-1
- mN_icb_cmd_wdata / mN_icb_cmd_wmask  in  WIDTH/MW  write beat data/mask
- mN_icb_w_valid / mN_icb_w_ready  in/out  1  write beat handshake
- mN_icb_rsp_valid  out  1  response valid
- mN_icb_rsp_ready  in  1  response ready
- mN_icb_rsp_rdata / mN_icb_rsp_err  out  WIDTH/1  response data/error
- s_icb_*  (cmd_valid, cmd_addr, cmd_read, cmd_len, cmd_wdata, cmd_wmask, w_valid, rsp_ready out; cmd_ready, w_ready, rsp_valid, rsp_rdata, rsp_err in), same widths, to bridge
- arb_busy  out  1  state != IDLE
- arb_gnt  out  1  current/last granted master index

Behaviour:
- States: IDLE, CMD, WDATA, RSP. Regs: state, gnt, last_gnt, beats (LEN_W+1 bits), w_cnt (LEN_W+1 bits), is_rd.
- Reset, checked before all else:
  - state=IDLE, gnt=0, last_gnt=1 (so m0 wins the first tie), counters=0.
  - All valid/ready outputs to masters and slave are 0; rdata=0, err=0.
  - A reset mid-burst abandons the transaction; the bridge is reset together with this block.
- IDLE:
  - No routing: all mN ready/valid = 0, all s_icb valids = 0.
  - If any mN_cmd_valid: gnt = the requester other than last_gnt if it requests, else the sole requester.
  - Next state is CMD. Arbitration latency is 1 cycle.
- CMD:
  - s_cmd_* = granted master's cmd fields; granted mN_cmd_ready = s_cmd_ready.
  - On the s_cmd handshake: beats=len+1, is_rd=read.
    - Read: go to RSP.
    - Write: go to WDATA, or directly to RSP if w_cnt already == len+1.
- W channel:
  - Routed to gnt while in CMD (only when the granted cmd_read=0) and in WDATA; blocked elsewhere (w_ready=0).
  - w_cnt increments on each s_w handshake.
  - WDATA → RSP on the handshake that makes w_cnt == beats. Further w_valid in that beat cycle is not passed (w_ready=0 after the count is reached).
- RSP:
  - s_rsp_ready = granted mN_rsp_ready; granted mN_rsp_valid/rdata/err = slave's.
  - Expected beats: read = beats, write = 1.
  - Each rsp handshake decrements beats (a write forces the last-beat condition).
  - On the last handshake: last_gnt=gnt, w_cnt=0, go to IDLE. A new grant is possible the next cycle, so there is a 1-cycle bubble between transactions.
- rsp_err is passed through per beat and never aborts a burst.
- Non-granted master, all states: cmd_ready=0, w_ready=0, rsp_valid=0, rdata=0, err=0.
- Slave rsp_valid outside RSP is ignored (s_rsp_ready=0). This is a protocol error, flagged by a bench assertion.
- Both masters requesting continuously alternate strictly m0,m1,m0,...
- A master that drops cmd_valid after being granted and before the handshake keeps the grant until it completes.
- len=max (7): 8 beats; counters are LEN_W+1 bits, so there is no wrap.
- arb_busy = (state!=IDLE); arb_gnt = gnt.

Decomposition:
- Package icb_arb_pkg:
  - arb_state_e enum {IDLE, CMD, WDATA, RSP}
  - localparam NUM_M=2
- Sub-module icb_rr_pick2: combinational 2-way round-robin pick.
  - Inputs: req[1:0], last_gnt.
  - Outputs: gnt_id, any_req.
  - Reusable if NUM_M grows.

Test Plan:
- Single read: m0 read addr 0x100, len=3, slave returns 0xA0..0xA3 → m0 sees 4 rsp beats in order; m1 sees rsp_valid=0 throughout; arb_busy drops 1 cycle after the last beat.
- Write with early W: m1 write len=1, w_valid asserted in the same cycle as cmd_valid, data 0xDEAD/0xBEEF mask 0xF → slave sees 2 w beats in order, 1 rsp to m1, then IDLE.
- Simultaneous requests: both masters cmd_valid=1 from reset with 3 single-beat reads each → slave grant order m0,m1,m0,m1,m0,m1.
- Backpressure: s_cmd_ready low 5 cycles, m0 rsp_ready toggles 1/0 on a len=7 read → exactly 8 beats delivered, none lost or duplicated.
- Error beat: slave asserts rsp_err on beat 2 of a 4-beat read → m0 sees err=1 only on beat 2; all 4 beats are delivered.
- Reset mid-burst: rst=1 during WDATA after 1 of 4 beats → next cycle state=IDLE, all valids 0, last_gnt=1; a following m1-only request is granted.
